// File: rtl/fp_result_collector.sv
// fp_result_collector
// Writeback stage behind the combinational fp_msub unit.
// - Captures each accepted result and its exception flags {nv, of, uf} into a small FIFO.
// - Presents the FIFO head to the consumer over a valid/ready handshake.
// - Keeps the sticky exception flags and a saturating count of accepted operations.
// Optional build macro FP_RES_CANON_NAN_EN: when defined, NaN results are stored
// as the canonical quiet NaN 32'h7FC00000 (sign and payload dropped). When
// undefined, results are stored bit-exact. The flag logic is the same either way.
module fp_result_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_result,
    input  logic                       in_overflow,
    input  logic                       in_underflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [2:0]                 out_flags,
    output logic [2:0]                 fflags,
    input  logic                       fflags_clr,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           op_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [2:0]       fflags_q, fflags_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [31:0]      mem_res_q [DEPTH];
    logic [31:0]      mem_res_d [DEPTH];
    logic [2:0]       mem_flg_q [DEPTH];
    logic [2:0]       mem_flg_d [DEPTH];

    logic             in_nv;
    logic [2:0]       in_flags;
    logic [31:0]      store_result;
    logic             accept;
    logic             pop;

    // Input flag derivation and the value actually written into the FIFO
    always_comb begin
        in_nv    = (in_result[30:23] == 8'hFF) && (in_result[22:0] != '0);
        in_flags = {in_nv, in_overflow, in_underflow};
`ifdef FP_RES_CANON_NAN_EN
        store_result = in_nv ? 32'h7FC0_0000 : in_result;
`else
        store_result = in_result;
`endif
    end

    // Handshake decode; in_ready deliberately ignores out_ready so a full FIFO never accepts
    always_comb begin
        in_ready  = (level_q != LW'(DEPTH));
        out_valid = (level_q != '0);
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Pointer, occupancy, sticky flag and counter next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        fflags_d   = fflags_q;
        op_count_d = op_count_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({accept, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Clear is applied before the set so a same-cycle accept survives the clear
        if (fflags_clr) begin
            fflags_d = '0;
        end
        if (accept) begin
            fflags_d = fflags_d | in_flags;
        end

        if (accept && (op_count_q != '1)) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    // Storage write on accept
    always_comb begin
        mem_res_d = mem_res_q;
        mem_flg_d = mem_flg_q;
        if (accept) begin
            mem_res_d[wr_ptr_q] = store_result;
            mem_flg_d[wr_ptr_q] = in_flags;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            fflags_q   <= '0;
            op_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            fflags_q   <= fflags_d;
            op_count_q <= op_count_d;
        end
    end

    // Storage registers; contents are masked by level so they need no reset
    always_ff @(posedge clk) begin
        mem_res_q <= mem_res_d;
        mem_flg_q <= mem_flg_d;
    end

    // Head presentation, zeroed while empty
    always_comb begin
        out_result = '0;
        out_flags  = '0;
        if (out_valid) begin
            out_result = mem_res_q[rd_ptr_q];
            out_flags  = mem_flg_q[rd_ptr_q];
        end
        fflags   = fflags_q;
        level    = level_q;
        op_count = op_count_q;
    end

endmodule

// File: tb/tb_fp_result_collector.sv
// Self-checking bench for fp_result_collector: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_fp_result_collector;

    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_result;
    logic          in_overflow;
    logic          in_underflow;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_result;
    logic [2:0]    out_flags;
    logic [2:0]    fflags;
    logic          fflags_clr;
    logic [LW-1:0] level;
    logic [15:0]   op_count;

    logic          in_ready2;
    logic          out_valid2;
    logic [31:0]   out_result2;
    logic [2:0]    out_flags2;
    logic [2:0]    fflags2;
    logic [LW-1:0] level2;
    logic [1:0]    op_count2;

    always #5 clk = ~clk;

    fp_result_collector #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_overflow(in_overflow), .in_underflow(in_underflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .fflags(fflags), .fflags_clr(fflags_clr),
        .level(level), .op_count(op_count)
    );

    fp_result_collector #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .in_result(in_result),
        .in_overflow(in_overflow), .in_underflow(in_underflow),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_result(out_result2), .out_flags(out_flags2),
        .fflags(fflags2), .fflags_clr(fflags_clr),
        .level(level2), .op_count(op_count2)
    );

    // Reference model: an ordered list of pending entries plus sticky flags and counts
    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flg;
    } ent_t;

    ent_t        q[$];
    logic [2:0]  m_ff;
    int unsigned m_cnt;
    int unsigned m_cnt2;

    int checks = 0;
    int errors = 0;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_res;
        logic [2:0]  e_flg;
        e_res = (q.size() != 0) ? q[0].res : 32'h0;
        e_flg = (q.size() != 0) ? q[0].flg : 3'b000;
        chk("out_valid",  32'(out_valid),  32'(q.size() != 0));
        chk("out_result", out_result,      e_res);
        chk("out_flags",  32'(out_flags),  32'(e_flg));
        chk("fflags",     32'(fflags),     32'(m_ff));
        chk("level",      32'(level),      q.size());
        chk("op_count",   32'(op_count),   m_cnt);
        chk("in_ready",   32'(in_ready),   32'(q.size() != DEPTH));
        chk("sat_op_count", 32'(op_count2), m_cnt2);
        chk("sat_level",    32'(level2),    q.size());
        chk("sat_out_valid", 32'(out_valid2), 32'(q.size() != 0));
        chk("sat_out_result", out_result2, e_res);
        chk("sat_out_flags", 32'(out_flags2), 32'(e_flg));
        chk("sat_fflags",   32'(fflags2),   32'(m_ff));
        chk("sat_in_ready", 32'(in_ready2), 32'(q.size() != DEPTH));
    endtask

    // One clock cycle: drive inputs, check combinational ready, advance model, check outputs
    task automatic step(input logic v, input logic [31:0] res, input logic ovf, input logic unf,
                        input logic rdy, input logic clr, input logic rs);
        logic acc;
        logic pp;
        ent_t e;
        in_valid     = v;
        in_result    = res;
        in_overflow  = ovf;
        in_underflow = unf;
        out_ready    = rdy;
        fflags_clr   = clr;
        rst          = rs;
        #1;
        if (!rs) begin
            chk("in_ready_pre", 32'(in_ready), 32'(q.size() != DEPTH));
        end
        if (rs) begin
            q.delete();
            m_ff   = 3'b000;
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            acc = v && (q.size() != DEPTH);
            pp  = (q.size() != 0) && rdy;
            if (pp) void'(q.pop_front());
            if (clr) m_ff = 3'b000;
            if (acc) begin
                e.flg = {is_nan(res), ovf, unf};
`ifdef FP_RES_CANON_NAN_EN
                e.res = is_nan(res) ? 32'h7FC00000 : res;
`else
                e.res = res;
`endif
                q.push_back(e);
                m_ff = m_ff | e.flg;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] vals [4];
        logic [31:0] r;
        int unsigned kind;
        vals[0] = 32'h3F800000;
        vals[1] = 32'hC1000000;
        vals[2] = 32'h41300000;
        vals[3] = 32'h7F800000;

        q.delete();
        m_ff = 3'b000; m_cnt = 0; m_cnt2 = 0;
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_overflow = 1'b0;
        in_underflow = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
        @(posedge clk);
        #1;

        // Reset state and single pass-through
        step(0, 32'h0, 0, 0, 0, 0, 1);
        step(1, 32'hBF800000, 0, 0, 1, 0, 0);
        chk("single_result", out_result, 32'hBF800000);
        step(0, 32'h0, 0, 0, 1, 0, 0);

        // Fill, blocked fifth push, drain in order (Inf leaves flags clear)
        for (int i = 0; i < 4; i++) step(1, vals[i], 0, 0, 0, 0, 0);
        step(1, 32'h40400000, 0, 0, 0, 0, 0);
        chk("full_level", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 0, 1, 0, 0);

        // NaN then overflow: sticky accumulation
        step(1, 32'hFFC00001, 0, 0, 0, 0, 0);
        chk("nan_fflags", 32'(fflags), 32'b100);
        step(1, 32'h40000000, 1, 0, 0, 0, 0);
        chk("of_fflags", 32'(fflags), 32'b110);
        step(0, 32'h0, 0, 0, 1, 0, 0);
        step(0, 32'h0, 0, 0, 1, 0, 0);

        // Clear racing an accept with underflow
        step(1, 32'h3F800000, 0, 1, 1, 1, 0);
        chk("clr_race", 32'(fflags), 32'b001);
        step(0, 32'h0, 0, 0, 1, 1, 0);

        // Simultaneous push/pop at level 2 across the pointer wrap
        step(0, 32'h0, 0, 0, 0, 0, 1);
        step(1, 32'h11111111, 0, 0, 0, 0, 0);
        step(1, 32'h22222222, 0, 0, 0, 0, 0);
        step(1, 32'h33333333, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 1, 0, 0);
        step(1, 32'h44444444, 0, 0, 1, 0, 0);
        chk("wrap_level", 32'(level), 32'd2);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0, 1, 0, 0);

        // Mid-stream reset, then saturation of the narrow counter
        for (int i = 0; i < 3; i++) step(1, 32'h40A00000, 1, 1, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 1);
        chk("rst_op_count", 32'(op_count), 32'd0);
        for (int i = 0; i < 5; i++) step(1, 32'h3F000000, 0, 0, 1, 0, 0);
        chk("sat_five", 32'(op_count2), 32'd3);
        step(0, 32'h0, 0, 0, 1, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 3);
            r = $urandom;
            if (kind == 1) r = {r[31], 8'hFF, r[22:1], 1'b1};
            else if (kind == 2) r = {r[31], 8'hFF, 23'd0};
            step($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
- Downstream stage of the combinational fp_msub unit (a*b - c, IEEE-754 binary32).
- Captures each valid result with its exception indications into a small FIFO and presents it to the consumer over a valid/ready handshake.
- Maintains sticky exception flags (NV, OF, UF) and a saturating operation counter, acting as the result/flag writeback point of the FP datapath.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a result on in_result.
- in_ready  output  1  collector can accept this cycle.
- in_result  input  32  fp_result from fp_msub.
- in_overflow  input  1  overflow from fp_msub.
- in_underflow  input  1  underflow from fp_msub.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer takes the head this cycle.
- out_result  output  32  head result.
- out_flags  output  3  head flags {nv, of, uf}.
- fflags  output  3  sticky flags {NV, OF, UF}.
- fflags_clr  input  1  clears the sticky flags.
- level  output  $clog2(DEPTH)+1  current occupancy.
- op_count  output  CNT_W  accepted operations, saturating.

Behaviour:
- Reset (rst=1 at a clock edge), applied mid-operation or otherwise:
  - wr_ptr, rd_ptr, level, fflags and op_count all go to 0; pending entries are discarded.
  - out_valid=0, out_result=0, out_flags=0, in_ready=1 in the cycle after the edge.
- Flag derivation at input, combinational:
  - nv = (in_result[30:23]==8'hFF) && (in_result[22:0]!=0).
  - of = in_overflow, uf = in_underflow.
  - Infinity (mantissa 0) does not set nv.
- Accept rules:
  - accept = in_valid && in_ready; in_ready = (level != DEPTH).
  - On accept, {result, nv, of, uf} is written at wr_ptr and wr_ptr increments modulo DEPTH.
  - in_result and the flags are sampled only on accept; their value is ignored otherwise.
- Pop rules:
  - pop = out_valid && out_ready; out_valid = (level != 0).
  - On pop, rd_ptr increments modulo DEPTH.
  - out_result and out_flags show mem[rd_ptr] when out_valid=1, and 0 when empty.
- Latency and bypass:
  - Latency from accept to out_valid is 1 cycle; there is no combinational bypass when empty.
  - in_ready does not depend on out_ready: when full, in_ready=0 even if a pop occurs in the same cycle.
- Simultaneous accept and pop (only possible when 0 < level < DEPTH): level is unchanged and both pointers advance.
- Level update: accept only gives level+1; pop only gives level-1.
- Pointer wrap: pointers wrap from DEPTH-1 to 0; full versus empty is resolved by level, never by pointer equality alone.
- Sticky flags:
  - On accept, fflags |= {nv, of, uf}.
  - fflags_clr with no accept gives fflags = 0.
  - fflags_clr in the same cycle as an accept gives fflags = {nv, of, uf} of that entry: clear first, then the set is applied.
  - fflags is updated at accept time, not pop time.
- op_count increments on each accept and saturates at 2^CNT_W-1. It is cleared only by rst.
- Stall tolerance:
  - Protocol: out_result and out_flags hold stable while out_valid=1 and out_ready=0.
  - Protocol: the producer may drop in_valid at any time; nothing is required of it.

Optional Feature:
- Macro: FP_RES_CANON_NAN_EN.
- Defined: any NaN result (nv=1) is stored as canonical 32'h7FC00000, sign dropped, and nv is still recorded.
- Undefined: the result is stored bit-exact, so a NaN payload and sign pass through unchanged.
- In both builds the flag logic is identical.

Test Plan:
- Reset then single pass:
  - Stimulus: after rst, accept 32'hBF800000 with of=0, uf=0 and out_ready=1.
  - Response: the next cycle out_valid=1, out_result=BF800000, out_flags=000.
  - Then level returns 0, op_count=1, fflags=000.
- Fill, stall and drain:
  - Stimulus: out_ready=0; push 3F800000, C1000000, 41300000, 7F800000, then attempt a fifth push.
  - Response: in_ready=0 with level=4 and the fifth push is not accepted.
  - Drain with out_ready=1 returns the same order; out_flags are all 000, including for the Inf.
- NaN and stickiness:
  - Stimulus: accept FFC00001, then 40000000 with overflow=1.
  - Response: fflags=100 and then 110.
  - Out_result of the first entry is FFC00001 without the macro and 7FC00000 with it.
- Clear race:
  - Stimulus: fflags=110; assert fflags_clr in the same cycle as accepting an entry with underflow=1.
  - Response: fflags=001.
- Simultaneous push and pop at level 2 across the pointer wrap (wr_ptr=3):
  - Response: level stays 2, wr_ptr wraps to 0, and data order is preserved.
- Mid-stream reset and saturation:
  - Stimulus: rst while level=3.
  - Response: next cycle out_valid=0, level=0, op_count=0.
  - Separately, with CNT_W=2, five accepts leave op_count=3.
